cache_req_arbiter: RTL and testbench
====================================

# cache_req_arbiter

Round-robin arbiter that shares the single cache `controller` between `NUM_REQ` requester ports. It accepts one request at a time over a valid/ready handshake and presents it to the controller as a one-cycle `operation_e` pulse with key and value. It then waits for the controller's done or error indication and returns the result to the granted requester. It sits between the host-side request ports and the controller's `operation_in`.

## Interface
- `NUM_REQ`, 4: number of requester ports; must be ≥2.
- `KEY_WIDTH`, 16: key width in bits.
- `VAL_WIDTH`, 32: value width in bits.
- `TIMEOUT`, 255: maximum number of cycles spent in WAIT before the arbiter forces an error.

- `clk`  in  1  the only clock. Every register samples on the rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-high.
- `req_valid`  in  NUM_REQ  per-port request valid.
- `req_op`  in  NUM_REQ×operation_e  per-port operation (`ctrl_types_pkg`).
- `req_key`  in  NUM_REQ×KEY_WIDTH  per-port key.
- `req_value`  in  NUM_REQ×VAL_WIDTH  per-port write value.
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `resp_valid`  out  NUM_REQ  one-hot response valid.
- `resp_ready`  in  NUM_REQ  per-port response accept.
- `resp_value`  out  VAL_WIDTH  read data, shared across ports.
- `resp_error`  out  1  the operation failed, shared across ports.
- `ctrl_op`  out  operation_e  to `controller.operation_in`. Held at NOOP when not issuing.
- `ctrl_key`  out  KEY_WIDTH  latched key.
- `ctrl_value`  out  VAL_WIDTH  latched value.
- `ctrl_done`  in  1  controller completion pulse.
- `ctrl_error`  in  1  controller error pulse.
- `ctrl_rdata`  in  VAL_WIDTH  controller read data, valid with `ctrl_done`.

## Operation
- States: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP. A register `ptr` (width $clog2(NUM_REQ)) holds the round-robin priority.
- ARB_IDLE:
  - Grant `g` is the first index with `req_valid` set, searching from `ptr` upward and wrapping modulo NUM_REQ.
  - `req_ready[g]` is driven high combinationally in this same cycle, which completes the handshake.
  - On that edge the arbiter latches `g`, `req_op[g]`, `req_key[g]` and `req_value[g]`.
  - If the latched op is NOOP: go to ARB_RESP with the error flag set and value 0. The request is not issued to the controller.
  - Otherwise go to ARB_ISSUE.
  - With no `req_valid` bit set, the arbiter stays in ARB_IDLE.
- ARB_ISSUE:
  - `ctrl_op` is driven with the latched op for exactly this one cycle.
  - The timeout counter is cleared.
  - Go to ARB_WAIT.
- ARB_WAIT:
  - `ctrl_op` is NOOP.
  - On `ctrl_error`: latch error=1 and value=0.
  - On `ctrl_done`: latch error=0 and value=`ctrl_rdata`.
  - If both arrive in the same cycle, error wins.
  - Either event moves the FSM to ARB_RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT, latch error=1 and go to ARB_RESP.
- ARB_RESP:
  - `resp_valid[g]` is held high and `resp_value`/`resp_error` are held stable until `resp_ready[g]` is seen.
  - On that handshake: `ptr` ← (g+1) mod NUM_REQ, then go to ARB_IDLE.
  - `resp_ready` on any other port is ignored.
- `ctrl_key` and `ctrl_value` hold the latched request from ARB_ISSUE until the next grant.
- `req_ready` is 0 in every state except ARB_IDLE, so at most one request is outstanding.

## Timing
- Reset values: state ARB_IDLE, `ptr` 0, `req_ready` 0, `resp_valid` 0, `resp_value` 0, `resp_error` 0, `ctrl_op` NOOP, `ctrl_key` 0, `ctrl_value` 0, counter 0.
- Accept edge to `ctrl_op` pulse: 1 cycle.
- A controller done in cycle N gives `resp_valid` in cycle N+1.
- Minimum turnaround for a response accepted immediately: 4 cycles (IDLE→ISSUE→WAIT→RESP→IDLE) plus the controller latency.
- A timeout yields `resp_valid` TIMEOUT+2 cycles after ARB_ISSUE.
- Reset asserted mid-operation:
  - All state is cleared immediately. No response is produced for the aborted request.
  - `ctrl_op` returns to NOOP asynchronously.
- A requester must keep `req_valid` and its payload stable until `req_ready`. Dropping `req_valid` earlier withdraws the request.

## Test plan
- Single READ on port 2, key 0x00A5; controller returns done with rdata 0xDEADBEEF after 3 cycles → `req_ready`=0b0100, one `ctrl_op`=READ pulse, then `resp_valid`=0b0100, `resp_value`=0xDEADBEEF, `resp_error`=0.
- All four ports valid continuously, controller done after 1 cycle → grant order 0,1,2,3,0. `ptr` wraps from 3 to 0 and no port is starved.
- CREATE on port 1 with `ctrl_error` and `ctrl_done` pulsed in the same cycle → `resp_error`=1, `resp_value`=0.
- TIMEOUT=8, controller never responds → `resp_valid[g]` asserts 10 cycles after ARB_ISSUE with `resp_error`=1. The next request is then accepted normally.
- NOOP request on port 3 → accepted, `ctrl_op` stays NOOP throughout, `resp_valid`=0b1000 with `resp_error`=1. `resp_ready` withheld for 5 cycles keeps the response stable.
- `rst` pulsed while in ARB_WAIT → all outputs at reset values within the same cycle. A subsequent request on port 0 is served normally.

Source files
------------

// File: rtl/cache_req_arbiter_if.sv
// cache_req_arbiter_if: operation types plus the requester/controller bus seen by the arbiter.
package ctrl_types_pkg;
    typedef enum logic [2:0] {NOOP = 3'd0, READ, CREATE, UPDATE, DELETE} operation_e;
endpackage

interface cache_req_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int KEY_WIDTH = 16,
    parameter int VAL_WIDTH = 32
);
    logic [NUM_REQ-1:0]                          req_valid;
    ctrl_types_pkg::operation_e [NUM_REQ-1:0]    req_op;
    logic [NUM_REQ-1:0][KEY_WIDTH-1:0]           req_key;
    logic [NUM_REQ-1:0][VAL_WIDTH-1:0]           req_value;
    logic [NUM_REQ-1:0]                          req_ready;
    logic [NUM_REQ-1:0]                          resp_valid;
    logic [NUM_REQ-1:0]                          resp_ready;
    logic [VAL_WIDTH-1:0]                        resp_value;
    logic                                        resp_error;
    ctrl_types_pkg::operation_e                  ctrl_op;
    logic [KEY_WIDTH-1:0]                        ctrl_key;
    logic [VAL_WIDTH-1:0]                        ctrl_value;
    logic                                        ctrl_done;
    logic                                        ctrl_error;
    logic [VAL_WIDTH-1:0]                        ctrl_rdata;

    modport slave (
        input  req_valid, req_op, req_key, req_value, resp_ready, ctrl_done, ctrl_error, ctrl_rdata,
        output req_ready, resp_valid, resp_value, resp_error, ctrl_op, ctrl_key, ctrl_value
    );
    modport master (
        output req_valid, req_op, req_key, req_value, resp_ready, ctrl_done, ctrl_error, ctrl_rdata,
        input  req_ready, resp_valid, resp_value, resp_error, ctrl_op, ctrl_key, ctrl_value
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin sharing of one cache controller among NUM_REQ requesters,
// one outstanding request at a time, with a watchdog on controller completion.
module cache_req_arbiter
    import ctrl_types_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int KEY_WIDTH = 16,
    parameter int VAL_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input logic             clk,
    input logic             rst,
    cache_req_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} state_e;

    state_e        state, state_nxt;
    logic [PW-1:0] ptr, gnt, g_q;
    logic          any;
    operation_e    op_q;
    logic [CW-1:0] cnt;
    logic          timeout;

    function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] v, int k);
        int s;
        s = int'(v) + k;
        return PW'(s >= NUM_REQ ? s - NUM_REQ : s);
    endfunction

    // Walk downward so the closest valid index at or after ptr is the last one written.
    always_comb begin
        gnt = ptr;
        any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[wrap_add(ptr, i)]) begin
                gnt = wrap_add(ptr, i);
                any = 1'b1;
            end
        end
    end

    assign timeout = cnt == CW'(TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (any) state_nxt = bus.req_op[gnt] == NOOP ? ARB_RESP : ARB_ISSUE;
            ARB_ISSUE: state_nxt = ARB_WAIT;
            ARB_WAIT:  if (bus.ctrl_error || bus.ctrl_done || timeout) state_nxt = ARB_RESP;
            ARB_RESP:  if (bus.resp_ready[g_q]) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == ARB_IDLE && any) ? NUM_REQ'(1) << gnt : '0;
        bus.resp_valid = state == ARB_RESP ? NUM_REQ'(1) << g_q : '0;
        bus.ctrl_op    = state == ARB_ISSUE ? op_q : NOOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr            <= '0;
            g_q            <= '0;
            op_q           <= NOOP;
            cnt            <= '0;
            bus.ctrl_key   <= '0;
            bus.ctrl_value <= '0;
            bus.resp_value <= '0;
            bus.resp_error <= 1'b0;
        end else begin
            if (state == ARB_IDLE && any) begin
                g_q            <= gnt;
                op_q           <= bus.req_op[gnt];
                bus.ctrl_key   <= bus.req_key[gnt];
                bus.ctrl_value <= bus.req_value[gnt];
                if (bus.req_op[gnt] == NOOP) begin
                    bus.resp_error <= 1'b1;
                    bus.resp_value <= '0;
                end
            end
            if (state == ARB_ISSUE) cnt <= '0;
            // Controller events take precedence over the watchdog; error beats done.
            if (state == ARB_WAIT) begin
                if (bus.ctrl_error || (!bus.ctrl_done && timeout)) begin
                    bus.resp_error <= 1'b1;
                    bus.resp_value <= '0;
                end else if (bus.ctrl_done) begin
                    bus.resp_error <= 1'b0;
                    bus.resp_value <= bus.ctrl_rdata;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == ARB_RESP && bus.resp_ready[g_q]) ptr <= wrap_add(g_q, 1);
        end
    end
endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: vector table, hand sequences and randomized traffic checked against
// a transaction-level round-robin model.
module tb_cache_req_arbiter;
    import ctrl_types_pkg::*;

    localparam int NUM = 4, KW = 16, VW = 32, TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_req_arbiter_if #(.NUM_REQ(NUM), .KEY_WIDTH(KW), .VAL_WIDTH(VW)) bus();
    cache_req_arbiter #(.NUM_REQ(NUM), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    int n_chk = 0, n_fail = 0, m_ptr = 0, g_last;
    operation_e    p_op[NUM];
    logic [KW-1:0] p_key[NUM];
    logic [VW-1:0] p_val[NUM];

    typedef struct {
        int port; operation_e op; logic [KW-1:0] key; logic [VW-1:0] val;
        int lat; int ev; logic [VW-1:0] rdata; int hold;
        logic exp_err; logic [VW-1:0] exp_val;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_req_ready", 64'(bus.req_ready), 0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 0);
        chk("rst_resp_value", 64'(bus.resp_value), 0);
        chk("rst_resp_error", 64'(bus.resp_error), 0);
        chk("rst_ctrl_op", 64'(bus.ctrl_op), 64'(NOOP));
        chk("rst_ctrl_key", 64'(bus.ctrl_key), 0);
        chk("rst_ctrl_value", 64'(bus.ctrl_value), 0);
    endtask

    // ev: 0 = controller silent (watchdog), 1 = done, 2 = error, 3 = done and error together
    task automatic serve(input logic [NUM-1:0] mask, input logic [NUM-1:0] keep, input int lat,
                         input int ev, input logic [VW-1:0] rdata, input int hold,
                         input logic exp_err, input logic [VW-1:0] exp_val, output int g);
        logic [NUM-1:0] oh;
        int cyc;
        g = -1;
        for (int i = 0; i < NUM; i++) if (g < 0 && mask[(m_ptr + i) % NUM]) g = (m_ptr + i) % NUM;
        oh = NUM'(1) << g;
        for (int i = 0; i < NUM; i++) begin
            bus.req_op[i] = p_op[i]; bus.req_key[i] = p_key[i]; bus.req_value[i] = p_val[i];
        end
        bus.req_valid = mask;
        #1 chk("req_ready_grant", 64'(bus.req_ready), 64'(oh));
        @(negedge clk);
        bus.req_valid = mask & keep;
        #1;
        if (p_op[g] != NOOP) begin
            chk("issue_ctrl_op", 64'(bus.ctrl_op), 64'(p_op[g]));
            chk("issue_ctrl_key", 64'(bus.ctrl_key), 64'(p_key[g]));
            chk("issue_ctrl_value", 64'(bus.ctrl_value), 64'(p_val[g]));
            chk("issue_req_ready", 64'(bus.req_ready), 0);
            if (ev != 0) begin
                repeat (lat) @(negedge clk);
                #1 chk("wait_ctrl_op", 64'(bus.ctrl_op), 64'(NOOP));
                bus.ctrl_done = ev[0]; bus.ctrl_error = ev[1]; bus.ctrl_rdata = rdata;
                @(negedge clk);
                bus.ctrl_done = 1'b0; bus.ctrl_error = 1'b0;
                #1;
            end else begin
                cyc = 0;
                while (bus.resp_valid == 0 && cyc < 300) begin
                    @(negedge clk);
                    #1 cyc++;
                end
                chk("timeout_latency", 64'(cyc), 64'(TO + 2));
            end
        end else begin
            chk("noop_ctrl_op", 64'(bus.ctrl_op), 64'(NOOP));
        end
        chk("resp_valid", 64'(bus.resp_valid), 64'(oh));
        chk("resp_error", 64'(bus.resp_error), 64'(exp_err));
        if (ev != 0 || p_op[g] == NOOP) chk("resp_value", 64'(bus.resp_value), 64'(exp_val));
        for (int h = 0; h < hold; h++) begin
            bus.resp_ready = ~oh;
            @(negedge clk);
            #1;
            chk("hold_resp_valid", 64'(bus.resp_valid), 64'(oh));
            chk("hold_resp_error", 64'(bus.resp_error), 64'(exp_err));
            chk("hold_ctrl_op", 64'(bus.ctrl_op), 64'(NOOP));
        end
        bus.resp_ready = oh;
        @(negedge clk);
        bus.resp_ready = '0;
        #1 chk("resp_done", 64'(bus.resp_valid), 0);
        m_ptr = (g + 1) % NUM;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 chk_reset();
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        #1;
    endtask

    initial begin
        bus.req_valid = '0; bus.resp_ready = '0;
        bus.ctrl_done = 1'b0; bus.ctrl_error = 1'b0; bus.ctrl_rdata = '0;
        for (int i = 0; i < NUM; i++) begin
            bus.req_op[i] = NOOP; bus.req_key[i] = '0; bus.req_value[i] = '0;
            p_op[i] = NOOP; p_key[i] = '0; p_val[i] = '0;
        end
        vecs[0] = '{2, READ,   16'h00A5, 32'h0,        3, 1, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1, CREATE, 16'h0011, 32'h55AA55AA, 2, 3, 32'h11112222, 0, 1'b1, 32'h0};
        vecs[2] = '{3, NOOP,   16'h0033, 32'h33333333, 0, 1, 32'h0,        5, 1'b1, 32'h0};
        vecs[3] = '{0, READ,   16'h0C0C, 32'h0,        0, 0, 32'h0,        0, 1'b1, 32'h0};
        vecs[4] = '{0, UPDATE, 16'h0D0D, 32'hCAFEF00D, 1, 1, 32'h12345678, 1, 1'b0, 32'h12345678};
        vecs[5] = '{1, DELETE, 16'h0E0E, 32'h0,        4, 2, 32'h9999AAAA, 0, 1'b1, 32'h0};
        repeat (2) @(negedge clk);
        #1 chk_reset();
        rst = 1'b0;

        foreach (vecs[v]) begin
            p_op[vecs[v].port] = vecs[v].op;
            p_key[vecs[v].port] = vecs[v].key;
            p_val[vecs[v].port] = vecs[v].val;
            serve(NUM'(1) << vecs[v].port, '0, vecs[v].lat, vecs[v].ev, vecs[v].rdata, vecs[v].hold,
                  vecs[v].exp_err, vecs[v].exp_val, g_last);
            p_op[vecs[v].port] = NOOP;
        end

        do_reset();
        for (int p = 0; p < NUM; p++) begin
            p_op[p] = READ; p_key[p] = KW'(16'h0100 + p); p_val[p] = VW'(p);
        end
        for (int k = 0; k < 5; k++) begin
            serve('1, '1, 1, 1, VW'(32'hA0 + k), 0, 1'b0, VW'(32'hA0 + k), g_last);
            chk("rr_order", 64'(g_last), 64'(k % NUM));
        end
        bus.req_valid = '0;

        p_op[0] = READ; p_key[0] = 16'hBEEF; p_val[0] = 32'h0;
        for (int i = 0; i < NUM; i++) begin
            bus.req_op[i] = p_op[i]; bus.req_key[i] = p_key[i]; bus.req_value[i] = p_val[i];
        end
        @(negedge clk);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset();
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        #1 chk("abort_no_resp", 64'(bus.resp_valid), 0);
        serve(4'b0001, '0, 2, 1, 32'h0BADF00D, 0, 1'b0, 32'h0BADF00D, g_last);

        repeat (40) begin
            logic [NUM-1:0] mask;
            int r, ev, gm;
            logic [VW-1:0] rd;
            mask = NUM'($urandom_range(1, (1 << NUM) - 1));
            for (int p = 0; p < NUM; p++) begin
                p_op[p] = operation_e'($urandom_range(0, 4));
                p_key[p] = KW'($urandom); p_val[p] = $urandom;
            end
            r = $urandom_range(0, 9);
            ev = r == 0 ? 0 : r <= 6 ? 1 : r <= 8 ? 2 : 3;
            rd = $urandom;
            gm = -1;
            for (int i = 0; i < NUM; i++) if (gm < 0 && mask[(m_ptr + i) % NUM]) gm = (m_ptr + i) % NUM;
            serve(mask, '0, $urandom_range(1, 6), ev, rd, $urandom_range(0, 2),
                  p_op[gm] == NOOP || ev != 1, (p_op[gm] != NOOP && ev == 1) ? rd : '0, g_last);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
